// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - per-register load countdown scoreboard with flush, halt and stall counter
module hazard_scoreboard_unit #(
    parameter int NB_ADDR      = 5,
    parameter int N_REGS       = 2**NB_ADDR,
    parameter int LOAD_LATENCY = 1,
    parameter int NB_CNT       = 3,
    parameter int NB_PERF      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_id_valid,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    input  logic               i_id_uses_rs,
    input  logic               i_id_uses_rt,
    input  logic               i_id_is_load,
    input  logic [NB_ADDR-1:0] i_id_rd,
    input  logic               i_id_halt,
    input  logic               i_branch_taken,
    output logic               o_stall,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_id_ex_bubble,
    output logic               o_flush,
    output logic               o_halted,
    output logic [NB_PERF-1:0] o_stall_cycles
);

    localparam logic [NB_CNT-1:0] LAT = NB_CNT'(LOAD_LATENCY);

    logic [NB_CNT-1:0]  cnt [N_REGS];
    logic               halted;
    logic [NB_PERF-1:0] stall_cycles;

    logic hazard_rs;
    logic hazard_rt;
    logic stall;
    logic load_issue;
    logic halt_set;

    // r0 is hardwired zero, so a pending "load" to it can never be a real dependency
    always_comb begin
        hazard_rs  = (i_id_rs != '0) && (cnt[i_id_rs] != '0);
        hazard_rt  = (i_id_rt != '0) && (cnt[i_id_rt] != '0);
        stall      = i_id_valid & ~i_branch_taken &
                     ((i_id_uses_rs & hazard_rs) | (i_id_uses_rt & hazard_rt));
        load_issue = i_id_valid & i_id_is_load & ~stall & ~i_branch_taken &
                     ~halted & (i_id_rd != '0);
        halt_set   = i_id_valid & i_id_halt & ~stall & ~i_branch_taken;
    end

    // A fresh issue reloads the counter; everything else drains toward zero
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (load_issue && (i_id_rd == NB_ADDR'(i))) begin
                    cnt[i] <= LAT;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (halt_set) begin
                halted <= 1'b1;
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign o_stall        = stall;
    assign o_flush        = i_branch_taken;
    assign o_pc_write     = ~stall & ~halted;
    assign o_if_id_write  = ~stall & ~halted;
    assign o_id_ex_bubble = stall | halted;
    assign o_halted       = halted;
    assign o_stall_cycles = stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed table plus random checks of two latency configurations
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, urs, urt, ld, halt, br;
    logic [4:0] rs, rt, rd;

    logic [1:0]  st, pcw, ifw, bub, fl, hl;
    logic [15:0] pc1;
    logic [3:0]  pc3;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.LOAD_LATENCY(1), .NB_PERF(16)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_id_valid(valid), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_uses_rs(urs), .i_id_uses_rt(urt), .i_id_is_load(ld), .i_id_rd(rd),
        .i_id_halt(halt), .i_branch_taken(br), .o_stall(st[0]), .o_pc_write(pcw[0]),
        .o_if_id_write(ifw[0]), .o_id_ex_bubble(bub[0]), .o_flush(fl[0]),
        .o_halted(hl[0]), .o_stall_cycles(pc1));

    hazard_scoreboard_unit #(.LOAD_LATENCY(3), .NB_PERF(4)) dut3 (
        .i_clock(clk), .i_reset(rst_n), .i_id_valid(valid), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_uses_rs(urs), .i_id_uses_rt(urt), .i_id_is_load(ld), .i_id_rd(rd),
        .i_id_halt(halt), .i_branch_taken(br), .o_stall(st[1]), .o_pc_write(pcw[1]),
        .o_if_id_write(ifw[1]), .o_id_ex_bubble(bub[1]), .o_flush(fl[1]),
        .o_halted(hl[1]), .o_stall_cycles(pc3));

    int checks = 0;
    int errors = 0;

    // Reference model: each register records the first cycle at which it is safe to read
    int t = 0;
    int ready [2][32];
    bit mh [2];
    int mperf [2];
    int lat [2]  = '{1, 3};
    int pmax [2] = '{65535, 15};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0d", name, act, exp, t);
        end
    endtask

    function automatic bit hz(input int k, input logic [4:0] r);
        return (r != 0) && (t < ready[k][r]);
    endfunction

    function automatic bit mstall(input int k);
        return valid && !br && ((urs && hz(k, rs)) || (urt && hz(k, rt)));
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) ready[k][r] = 0;
            mh[k] = 0;
            mperf[k] = 0;
        end
    endtask

    task automatic check_all();
        bit es;
        for (int k = 0; k < 2; k++) begin
            es = mstall(k);
            chk($sformatf("stall%0d", k), st[k], es);
            chk($sformatf("pc_write%0d", k), pcw[k], !es && !mh[k]);
            chk($sformatf("if_id_write%0d", k), ifw[k], !es && !mh[k]);
            chk($sformatf("bubble%0d", k), bub[k], es || mh[k]);
            chk($sformatf("flush%0d", k), fl[k], br);
            chk($sformatf("halted%0d", k), hl[k], mh[k]);
            chk($sformatf("perf%0d", k), (k == 0) ? 32'(pc1) : 32'(pc3), mperf[k]);
        end
    endtask

    task automatic model_edge();
        bit es [2];
        for (int k = 0; k < 2; k++) es[k] = mstall(k);
        for (int k = 0; k < 2; k++) begin
            if (valid && ld && !es[k] && !br && !mh[k] && rd != 0) ready[k][rd] = t + 1 + lat[k];
            if (valid && halt && !es[k] && !br) mh[k] = 1;
            if (es[k] && mperf[k] < pmax[k]) mperf[k]++;
        end
        t++;
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input bit [4:0] s, input bit [4:0] u, input bit us,
                          input bit ut, input bit l, input bit [4:0] d, input bit h, input bit b);
        valid = v; rs = s; rt = u; urs = us; urt = ut; ld = l; rd = d; halt = h; br = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit v; bit [4:0] rs; bit [4:0] rt; bit urs; bit urt; bit ld; bit [4:0] rd;
        bit halt; bit br; bit es1; bit es3; bit ef;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0};
        tbl[13] = '{1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 9, 0, 1, 0, 1, 10, 0, 1, 0, 0, 1};
        tbl[15] = '{1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        cycle();

        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].ld,
                   tbl[i].rd, tbl[i].halt, tbl[i].br);
            #1;
            chk($sformatf("tbl%0d_stall_l1", i), st[0], tbl[i].es1);
            chk($sformatf("tbl%0d_stall_l3", i), st[1], tbl[i].es3);
            chk($sformatf("tbl%0d_flush", i), fl[0], tbl[i].ef);
            check_all();
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        #1;
        chk("tbl_perf_l1", pc1, 1);
        chk("tbl_perf_l3", pc3, 5);
        chk("tbl_halted", hl, 2'b11);
        chk("tbl_halt_pcw", pcw, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("halt_async_clear", hl, 2'b00);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a dependant is stalled must release the stall without a clock edge
        set_in(1, 0, 0, 0, 0, 1, 4, 0, 0);
        cycle();
        set_in(1, 4, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("midstall_before", st, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("midstall_async_drop", st, 2'b00);
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Repeated load/use pairs push the narrow counter into saturation
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 0, 0, 0, 1, 6, 0, 0);
            cycle();
            set_in(1, 6, 0, 1, 0, 0, 0, 0, 0);
            for (int j = 0; j < 4; j++) cycle();
        end
        #1;
        chk("sat_perf_l1", pc1, 6);
        chk("sat_perf_l3", pc3, 15);
        do_reset();

        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 99) == 0,
                   $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0 || ((mh[0] || mh[1]) && $urandom_range(0, 9) == 0)) begin
                #1;
                check_all();
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
